// File: rtl/nmcu_main_mem.sv
// Fixed-latency main-memory model: single-word writes, wrapping read bursts,
// and an in-order response pipeline MEM_LATENCY stages deep.
module nmcu_main_mem #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int MEM_SIZE_WORDS = 65536,
    parameter int MEM_LATENCY    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic                  req_write_en_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    output logic                  req_ready_o,
    output logic                  resp_valid_o,
    output logic [ADDR_WIDTH-1:0] resp_addr_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_hit_o,
    output logic                  busy_o
);

    localparam int IDX_W = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_next_idx;
    logic [IDX_W-1:0]      w_next_idx_nxt;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [LEN_WIDTH-1:0]  w_remaining_nxt;

    logic                  w_issue;
    logic [IDX_W-1:0]      w_issue_idx;
    logic [DATA_WIDTH-1:0] w_issue_data;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_req_idx;
    logic                  w_unused;

    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE_WORDS];

    logic [MEM_LATENCY-1:0] r_pv;
    logic [IDX_W-1:0]       r_pa [MEM_LATENCY];
    logic [DATA_WIDTH-1:0]  r_pd [MEM_LATENCY];

    assign w_req_idx = req_addr_i[IDX_W+1:2];
    assign w_unused  = &{1'b0, req_addr_i};

    // Next-state, burst bookkeeping and beat issue selection
    always_comb begin
        w_state_nxt     = r_state;
        w_next_idx_nxt  = r_next_idx;
        w_remaining_nxt = r_remaining;
        w_issue         = 1'b0;
        w_issue_idx     = '0;
        w_issue_data    = '0;
        w_mem_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_issue     = 1'b1;
                    w_issue_idx = w_req_idx;
                    if (req_write_en_i) begin
                        w_mem_we     = 1'b1;
                        w_issue_data = req_wdata_i;
                    end else begin
                        w_issue_data = r_mem[w_req_idx];
                        // len 0 and len 1 both mean a single beat
                        if (req_len_i > LEN_WIDTH'(1)) begin
                            w_state_nxt     = ST_BURST;
                            w_next_idx_nxt  = w_req_idx + IDX_W'(1'b1);
                            w_remaining_nxt = req_len_i - LEN_WIDTH'(1);
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_issue = 1'b0;
                end
            end
            ST_BURST: begin
                w_issue         = 1'b1;
                w_issue_idx     = r_next_idx;
                w_issue_data    = r_mem[r_next_idx];
                w_next_idx_nxt  = r_next_idx + IDX_W'(1'b1);
                w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
                if (r_remaining <= LEN_WIDTH'(1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM and burst counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_next_idx  <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_next_idx  <= w_next_idx_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Storage array, intentionally not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_req_idx] <= req_wdata_i;
        end
    end

    // Response delay line; idle stages carry zero addr/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pa[0] <= w_issue_idx;
            r_pd[0] <= w_issue_data;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign req_ready_o  = (r_state == ST_IDLE);
    assign resp_valid_o = r_pv[MEM_LATENCY-1];
    assign resp_addr_o  = {{(ADDR_WIDTH-IDX_W-2){1'b0}}, r_pa[MEM_LATENCY-1], 2'b00};
    assign resp_rdata_o = r_pd[MEM_LATENCY-1];
    assign resp_hit_o   = 1'b0;
    assign busy_o       = (r_state == ST_BURST) || (|r_pv);

endmodule

// File: tb/tb_nmcu_main_mem.sv
// Directed bench for nmcu_main_mem: vector table of single-word operations
// followed by hand-written burst, back-to-back, wrap and reset sequences.
module tb_nmcu_main_mem;

    localparam int LAT = 5;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  req_len;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_addr_o;
    logic [31:0] resp_rdata_o;
    logic        resp_hit_o;
    logic        busy_o;

    nmcu_main_mem dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_write_en_i(req_we),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_len_i     (req_len),
        .req_ready_o   (req_ready_o),
        .resp_valid_o  (resp_valid_o),
        .resp_addr_o   (resp_addr_o),
        .resp_rdata_o  (resp_rdata_o),
        .resp_hit_o    (resp_hit_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  len;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } rsp_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   inv_err = 0;
    int   inv_seen = 0;
    int   rd = 0;
    rsp_t act_q[$];
    rsp_t exp_q[$];
    vec_t vecs[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every response with its cycle; flag bad fields on idle cycles
    always @(negedge clk) begin
        if (resp_valid_o === 1'b1) act_q.push_back('{cyc, resp_addr_o, resp_rdata_o});
        if (resp_hit_o !== 1'b0 ||
            (resp_valid_o !== 1'b1 && (resp_addr_o !== 32'h0 || resp_rdata_o !== 32'h0)))
            inv_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto_neg(input int n);
        int k;
        k = 0;
        @(negedge clk);
        while (cyc < n && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic push_exp(input int c, input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{c, a, d});
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] len, output int t);
        logic acc;
        int   k;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_len   = len;
        acc = 1'b0;
        k   = 0;
        t   = -1;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = req_ready_o;
            t   = cyc;
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 (addr %0h)", addr);
        end
    endtask

    task automatic drain();
        rsp_t e;
        rsp_t a;
        int   k;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            k = 0;
            while (act_q.size() <= rd && k < 60) begin
                @(negedge clk);
                k++;
            end
            checks++;
            if (act_q.size() <= rd) begin
                errors++;
                $display("FAIL resp_timeout: got none expected cyc %0d addr %0h data %0h",
                         e.cyc, e.addr, e.data);
            end else begin
                a = act_q[rd];
                rd++;
                if (a.cyc != e.cyc || a.addr !== e.addr || a.data !== e.data) begin
                    errors++;
                    $display("FAIL resp: got cyc %0d addr %0h data %0h expected cyc %0d addr %0h data %0h",
                             a.cyc, a.addr, a.data, e.cyc, e.addr, e.data);
                end
            end
        end
        repeat (8) @(negedge clk);
        chk("extra_resp", act_q.size(), rd);
        rd = act_q.size();
        chk("idle_fields", inv_err, inv_seen);
        inv_seen = inv_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int t2;
        int prev;
        int bad;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_len   = 8'h0;

        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 8'd0, 32'h0000_0100, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         8'd1, 32'h0000_0100, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0200, 32'h1,         8'd0, 32'h0000_0200, 32'h1};
        vecs[3]  = '{1'b1, 32'h0000_0204, 32'h2,         8'd9, 32'h0000_0204, 32'h2};
        vecs[4]  = '{1'b1, 32'h0000_0208, 32'h3,         8'd1, 32'h0000_0208, 32'h3};
        vecs[5]  = '{1'b1, 32'h0000_020C, 32'h4,         8'd0, 32'h0000_020C, 32'h4};
        vecs[6]  = '{1'b1, 32'h0000_0300, 32'h55,        8'd0, 32'h0000_0300, 32'h55};
        vecs[7]  = '{1'b1, 32'h0003_FFFC, 32'hA5A5_0001, 8'd0, 32'h0003_FFFC, 32'hA5A5_0001};
        vecs[8]  = '{1'b1, 32'h0000_0002, 32'h1234_5678, 8'd0, 32'h0000_0000, 32'h1234_5678};
        vecs[9]  = '{1'b0, 32'h0000_020B, 32'h0,         8'd0, 32'h0000_0208, 32'h3};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         8'd1, 32'h0000_0000, 32'h1234_5678};

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", resp_valid_o, 1'b0);
        chk("rst_addr", resp_addr_o, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", req_ready_o, 1'b1);
        @(posedge clk);
        #1;

        // Single-word table, issued back to back
        prev = -1;
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].len, t);
            if (i > 0) chk("b2b_accept", t, prev + 1);
            prev = t;
            push_exp(t + LAT, vecs[i].exp_addr, vecs[i].exp_data);
        end
        drain();

        // Burst of 4
        issue(1'b0, 32'h0000_0200, 32'h0, 8'd4, t);
        goto_neg(t + 1); chk("burst_ready1", req_ready_o, 1'b0);
        goto_neg(t + 2); chk("burst_ready2", req_ready_o, 1'b0);
        goto_neg(t + 3); chk("burst_ready3", req_ready_o, 1'b0);
        goto_neg(t + 4); chk("burst_ready4", req_ready_o, 1'b1);
        goto_neg(t + 8); chk("burst_busy8", busy_o, 1'b1);
        goto_neg(t + 9); chk("burst_busy9", busy_o, 1'b0);
        push_exp(t + 5, 32'h200, 32'h1);
        push_exp(t + 6, 32'h204, 32'h2);
        push_exp(t + 7, 32'h208, 32'h3);
        push_exp(t + 8, 32'h20C, 32'h4);
        drain();

        // Back-to-back: len 2 then len 0
        issue(1'b0, 32'h0000_0200, 32'h0, 8'd2, t);
        issue(1'b0, 32'h0000_0300, 32'h0, 8'd0, t2);
        chk("b2b_burst_accept", t2, t + 2);
        push_exp(t + 5, 32'h200, 32'h1);
        push_exp(t + 6, 32'h204, 32'h2);
        push_exp(t + 7, 32'h300, 32'h55);
        drain();

        // Wrap-around with misaligned base
        issue(1'b0, 32'h0003_FFFE, 32'h0, 8'd2, t);
        push_exp(t + 5, 32'h0003_FFFC, 32'hA5A5_0001);
        push_exp(t + 6, 32'h0000_0000, 32'h1234_5678);
        drain();

        // Reset in the middle of a len-8 burst
        issue(1'b0, 32'h0000_0200, 32'h0, 8'd8, t);
        push_exp(t + 5, 32'h200, 32'h1);
        push_exp(t + 6, 32'h204, 32'h2);
        push_exp(t + 7, 32'h208, 32'h3);
        goto_neg(t + 7);
        #2 rst_n = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        chk("reset_quiet", bad, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready_o, 1'b1);
        chk("post_rst_busy", busy_o, 1'b0);
        drain();
        issue(1'b0, 32'h0000_0204, 32'h0, 8'd1, t);
        push_exp(t + 5, 32'h204, 32'h2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
